// File: rtl/prach_ditfft3_bf3_pkg.sv
// prach_pkg: shared PRACH sample types, phase type and 19->18 bit narrowing
package prach_pkg;
  localparam int PRACH_DW = 18;
  typedef struct packed {
    logic signed [PRACH_DW-1:0] re;
    logic signed [PRACH_DW-1:0] im;
  } sample_t;
  typedef logic [1:0] phase_t;
  function automatic logic signed [PRACH_DW-1:0] sat19to18(input logic signed [PRACH_DW:0] v, input logic sat);
    return (sat && v[PRACH_DW] != v[PRACH_DW-1]) ? {v[PRACH_DW], {(PRACH_DW-1){~v[PRACH_DW]}}} : v[PRACH_DW-1:0];
  endfunction
endpackage

// File: rtl/prach_ditfft3_bf3_if.sv
// prach_ditfft3_bf3_if: streamed sample bus into and out of the final radix-3 butterfly
interface prach_ditfft3_bf3_if;
  import prach_pkg::*;
  logic signed [PRACH_DW-1:0] din_dr, din_di, dout_dr, dout_di;
  logic din_dv, sync_in, dout_dv, sync_out;
  modport master (output din_dr, din_di, din_dv, sync_in, input dout_dr, dout_di, dout_dv, sync_out);
  modport slave (input din_dr, din_di, din_dv, sync_in, output dout_dr, dout_di, dout_dv, sync_out);
endinterface

// File: rtl/prach_ditfft3_bf3_delay.sv
// prach_ditfft3_bf3_delay: fixed-depth shift register with async reset
module prach_ditfft3_bf3_delay #(
  parameter int W = 1,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [D];
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '{default: '0};
    else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[D-1];
endmodule

// File: rtl/prach_ditfft3_bf3.sv
// prach_ditfft3_bf3: final radix-3 DIT butterfly; define PRACH_DITFFT3_BF3_SAT_EN to saturate instead of wrap
module prach_ditfft3_bf3
  import prach_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  prach_ditfft3_bf3_if.slave   bus
);
`ifdef PRACH_DITFFT3_BF3_SAT_EN
  localparam logic sat_en = 1'b1;
`else
  localparam logic sat_en = 1'b0;
`endif
  phase_t cnt, ph, ph_d;
  sample_t din, hold, x1, x2, y0_d, o;
  logic dv_d, sync_d;
  logic signed [PRACH_DW:0] s_re, s_im, d_re, d_im;
  assign ph   = (bus.din_dv && bus.sync_in) ? 2'd0 : cnt;
  assign din  = '{re: bus.din_dr, im: bus.din_di};
  assign s_re = 19'(hold.re) + 19'(din.re);
  assign s_im = 19'(hold.im) + 19'(din.im);
  assign d_re = 19'(hold.re) - 19'(din.re);
  assign d_im = 19'(hold.im) - 19'(din.im);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt  <= '0;
      hold <= '0;
      x1   <= '0;
      x2   <= '0;
    end else if (bus.din_dv) begin
      cnt <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
      if (ph == 2'd1) hold <= din;
      if (ph == 2'd2) begin
        x1 <= '{re: sat19to18(d_re, sat_en), im: sat19to18(d_im, sat_en)};
        x2 <= '{re: sat19to18(s_re, sat_en), im: sat19to18(s_im, sat_en)};
      end
    end
  // phase travels with the sample so the output mux knows which result to emit
  prach_ditfft3_bf3_delay #(.W($bits(sample_t) + 2), .D(3)) u_data (
    .clk(clk), .rst(rst), .d({ph, din}), .q({ph_d, y0_d})
  );
  prach_ditfft3_bf3_delay #(.W(2), .D(3)) u_ctrl (
    .clk(clk), .rst(rst), .d({bus.din_dv, bus.din_dv & bus.sync_in}), .q({dv_d, sync_d})
  );
  assign o            = (ph_d == 2'd0) ? y0_d : (ph_d == 2'd1) ? x1 : x2;
  assign bus.dout_dr  = o.re;
  assign bus.dout_di  = o.im;
  assign bus.dout_dv  = dv_d;
  assign bus.sync_out = sync_d;
endmodule

// File: tb/tb_prach_ditfft3_bf3.sv
// tb_prach_ditfft3_bf3: directed vectors with a per-cycle expectation table checked on the falling edge
module tb_prach_ditfft3_bf3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit exp_dv [512];
  bit exp_sync [512];
  bit exp_ck [512];
  logic [17:0] exp_dr [512];
  logic [17:0] exp_di [512];
  prach_ditfft3_bf3_if bus ();
  prach_ditfft3_bf3 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [17:0] nar(input int v);
`ifdef PRACH_DITFFT3_BF3_SAT_EN
    if (v > 131071) return 18'h1ffff;
    if (v < -131072) return 18'h20000;
`endif
    return 18'(v);
  endfunction
  task automatic send(input int re, input int im, input logic dv, input logic sy, input int xr, input int xi, input logic ck);
    bus.din_dr  = 18'(re);
    bus.din_di  = 18'(im);
    bus.din_dv  = dv;
    bus.sync_in = sy;
    exp_dv[cyc+3]   = dv;
    exp_sync[cyc+3] = dv & sy;
    exp_ck[cyc+3]   = dv & ck;
    exp_dr[cyc+3]   = 18'(xr);
    exp_di[cyc+3]   = 18'(xi);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask
  task automatic triple(input int ar, input int ai, input int br, input int bi, input int cr, input int ci, input logic sy);
    send(ar, ai, 1'b1, sy, ar, ai, 1'b1);
    send(br, bi, 1'b1, 1'b0, int'($signed(nar(br - cr))), int'($signed(nar(bi - ci))), 1'b1);
    send(cr, ci, 1'b1, 1'b0, int'($signed(nar(br + cr))), int'($signed(nar(bi + ci))), 1'b1);
  endtask
  always @(negedge clk)
    if (mon_en) begin
      check("dout_dv", 18'(bus.dout_dv), 18'(exp_dv[cyc]));
      check("sync_out", 18'(bus.sync_out), 18'(exp_sync[cyc]));
      if (exp_ck[cyc]) begin
        check("dout_dr", bus.dout_dr, exp_dr[cyc]);
        check("dout_di", bus.dout_di, exp_di[cyc]);
      end
    end
  initial begin
    bus.din_dr = '0;
    bus.din_di = '0;
    bus.din_dv = 1'b0;
    bus.sync_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dr", bus.dout_dr, 18'd0);
    check("rst_di", bus.dout_di, 18'd0);
    check("rst_dv", 18'(bus.dout_dv), 18'd0);
    check("rst_sync", 18'(bus.sync_out), 18'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    send(100, 0, 1'b1, 1'b1, 100, 0, 1'b1);
    send(200, 0, 1'b1, 1'b0, 150, 20, 1'b1);
    send(50, -20, 1'b1, 1'b0, 250, -20, 1'b1);
    idle(2);
    for (int k = 0; k < 8; k++)
      triple(int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 262143)) - 131072,
             int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 262143)) - 131072,
             int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 262143)) - 131072, k == 0);
    idle(2);
    send(7, 7, 1'b1, 1'b1, 7, 7, 1'b1);
    send(131071, -131072, 1'b1, 1'b0, 131070, -131071, 1'b1);
`ifdef PRACH_DITFFT3_BF3_SAT_EN
    send(1, -1, 1'b1, 1'b0, 131071, -131072, 1'b1);
`else
    send(1, -1, 1'b1, 1'b0, -131072, 131071, 1'b1);
`endif
    idle(5);
    triple(-300, 40, 1000, -2000, -500, 600, 1'b0);
    idle(5);
    triple(11, 22, 33, 44, 55, 66, 1'b1);
    send(999, 999, 1'b1, 1'b1, 0, 0, 1'b0);
    triple(-5, 9, 70, -80, 12, 3, 1'b1);
    idle(4);
    send(1234, 1, 1'b1, 1'b1, 1234, 1, 1'b1);
    send(4321, 2, 1'b1, 1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_dr", bus.dout_dr, 18'd0);
    check("mid_rst_di", bus.dout_di, 18'd0);
    check("mid_rst_dv", 18'(bus.dout_dv), 18'd0);
    check("mid_rst_sync", 18'(bus.sync_out), 18'd0);
    for (int i = cyc; i < cyc + 6; i++) begin
      exp_dv[i] = 1'b0;
      exp_sync[i] = 1'b0;
      exp_ck[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    triple(400, -400, 30, 10, -70, 90, 1'b1);
    idle(4);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prach_ditfft3_bf3.md
# prach_ditfft3_bf3

Final butterfly stage of the serial radix-3 DIT FFT in the PRACH long-sequence path. Consumes the streamed triple (y0, y1, y2) from the second butterfly stage, where y0 = a+b+c, y1 = a−(b+c)/2 and y2 = +j·0.8660·(b−c). Emits the radix-3 DFT outputs X0 = y0, X1 = y1 − y2 and X2 = y1 + y2 in natural order. Output goes to the twiddle/reorder stage with fixed latency and no back-pressure.

## Interface
- No parameters. Data width is fixed at 18 bits through the shared package.
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- din_dr  in  18  signed real part of the input sample
- din_di  in  18  signed imaginary part of the input sample
- din_dv  in  1  input sample valid
- sync_in  in  1  marks y0 of the first triple of a symbol; qualified by din_dv
- dout_dr  out  18  signed real part of the output sample
- dout_di  out  18  signed imaginary part of the output sample
- dout_dv  out  1  output sample valid
- sync_out  out  1  sync_in delayed to line up with the matching X0

## Operation
- Phase counter cnt (0..2) advances only on din_dv:
  - A valid sample with sync_in high is phase 0, and the counter moves to 1.
  - Otherwise the counter goes 0→1→2→0.
  - sync_in with din_dv low is ignored.
- Phase 0 (y0): the sample enters a 3-deep delay line and is output unchanged as X0.
- Phase 1 (y1): y1 is captured into a hold register.
- Phase 2 (y2): compute S = y1 + y2 and D = y1 − y2 per component, each 19-bit. Store D (X1) and S (X2) into the result registers.
- Output mux, driven by the delayed phase:
  - phase 0 → delayed y0
  - phase 1 → X1 register
  - phase 2 → X2 register
- Narrowing from 19 to 18 bits is controlled by the macro in Configuration.
- Upstream contract: the three samples of a triple are valid on consecutive cycles. Gaps are allowed only between triples.
- Sync arriving mid-triple: the counter restarts at phase 0. Samples of the abandoned triple still emit dout_dv, but their data is unspecified. The new triple is correct.
- Reset mid-operation: the counter, hold/result registers, delay lines and all outputs clear immediately. The first triple after reset is processed correctly only if it begins with sync_in.

## Timing
- Latency is 3 cycles from each input sample to its output sample, for all phases. Example: y0 at t, y1 at t+1, y2 at t+2 give X0 at t+3, X1 at t+4, X2 at t+5.
- The X1/X2 result registers load at the end of cycle t+2. They are stable through t+5, and the next triple's y2 cannot overwrite them before the end of t+5.
- dout_dv and sync_out are din_dv and (sync_in & din_dv) delayed by exactly 3 cycles.
- Reset values: dout_dr = 0, dout_di = 0, dout_dv = 0, sync_out = 0, cnt = 0.
- Back-to-back triples run at full rate: one sample per cycle, no bubbles.

## Configuration
- PRACH_DITFFT3_BF3_SAT_EN defined: the 19-bit sums saturate to the range [−131072, 131071].
- PRACH_DITFFT3_BF3_SAT_EN undefined: the MSB is dropped (two's-complement wrap). This matches the cost of the other stages.

## Structure
- Package prach_pkg holds:
  - the PRACH_DW = 18 constant and the sample typedef (struct of signed re/im);
  - the phase typedef (2-bit);
  - a sat19to18 function, used by both build variants.
- Reuse the existing delay sub-module: one instance for the data path (width 36 plus phase, depth 3) and one for control (width 2, depth 3). Its reset is driven by rst.
- No other sub-modules.

## Test plan
- Triple y0 = (100,0), y1 = (200,0), y2 = (50,−20), with sync on y0 → outputs (100,0), (150,20), (250,−20) at cycles t+3..t+5; sync_out high only at t+3.
- 8 back-to-back triples with random values → output matches the reference model sample-for-sample; dout_dv continuous with no bubbles.
- y1 = (131071,−131072), y2 = (1,−1) → with SAT_EN, X2 = (131071,−131072); without it, X2 = (−131072,131071).
- Gap of 5 invalid cycles between triples → the counter holds, and the next triple's outputs are correct with 3-cycle latency.
- sync_in asserted on the second sample of a triple → the new triple realigns and its X0/X1/X2 are correct; the abandoned sample still emits dout_dv.
- rst asserted during phase 1 → all outputs read 0 in the next cycle, with no spurious dout_dv. After release, a synced triple processes correctly.
